coin_acceptor: RTL and testbench

- Front-end stage directly upstream of the vending FSM. Turns two raw, asynchronous, bouncy coin-sensor lines (5 rs, 10 rs) into the FSM's 2-bit per-cycle coin code: 00 = none, 01 = 5 rs, 10 = 10 rs.
- Synchronises and debounces each sensor, then emits exactly one single-cycle code per physical coin.
- Rejects simultaneous or inhibited insertions and enforces a lockout window between coins.

---
 rtl/coin_acceptor.sv | 113 +++++++++++
 tb/tb_coin_acceptor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises and debounces the 5 rs and 10 rs lines and
// hands the vending FSM one single-cycle coin code per physical coin.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       inhibit,
  output logic [1:0] coin_code,
  output logic       reject,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  // Bit 0 is the 5 rs channel, bit 1 the 10 rs channel, matching the coin code.
  logic [1:0] raw;
  logic [1:0] filt;
  logic [1:0] rise;

  assign raw = {coin10_raw, coin5_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic             sync1_reg;
      logic             sync2_reg;
      logic             filt_reg;
      logic             filt_d_reg;
      logic             rise_reg;
      logic [CNT_W-1:0] db_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          filt_reg   <= 1'b0;
          filt_d_reg <= 1'b0;
          rise_reg   <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg  <= raw[gi];
          sync2_reg  <= sync1_reg;
          filt_d_reg <= filt_reg;
          rise_reg   <= filt_reg & ~filt_d_reg;
          if (sync2_reg == filt_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg >= DB_LAST) begin
            filt_reg   <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + CNT_W'(1);
          end
        end
      end

      assign filt[gi] = filt_reg;
      assign rise[gi] = rise_reg;
    end
  endgenerate

  state_t           state_reg;
  logic [CNT_W-1:0] lock_cnt_reg;
  logic [1:0]       code_reg;
  logic             reject_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_LOCK;
      lock_cnt_reg <= LOCK_LOAD;
      code_reg     <= 2'b00;
      reject_reg   <= 1'b0;
    end else begin
      code_reg   <= 2'b00;
      reject_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (rise != 2'b00) begin
            state_reg    <= S_LOCK;
            lock_cnt_reg <= LOCK_LOAD;
            if (rise == 2'b11 || inhibit) begin
              reject_reg <= 1'b1;
            end else begin
              code_reg <= rise;
            end
          end
        end
        S_LOCK: begin
          if (lock_cnt_reg != '0) begin
            lock_cnt_reg <= lock_cnt_reg - CNT_W'(1);
          end
          // A coin still resting on a sensor keeps us locked so it cannot credit twice.
          if (lock_cnt_reg == '0 && filt == 2'b00) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_LOCK;
      endcase
    end
  end

  assign coin_code = code_reg;
  assign reject    = reject_reg;
  assign busy      = (state_reg == S_LOCK);

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed test-plan scenarios plus random sensor traffic,
// all checked cycle by cycle against a window-based behavioural model.
module tb_coin_acceptor;

  localparam int DB = 4;
  localparam int LK = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin5_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic       inhibit = 1'b0;
  logic [1:0] coin_code;
  logic       reject;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a channel's filtered level flips once the last DB synced
  // samples all disagree with it; lockout is measured as elapsed edges since entry.
  logic [63:0] m_shist [2];
  bit          m_rawp  [2];
  bit          m_filt  [2];
  bit          m_filtd [2];
  bit          m_rise  [2];
  bit          m_idle = 1'b0;
  int          m_cyc = 0;
  int          m_lock_start = 0;
  logic [1:0]  m_code = 2'b00;
  bit          m_rej = 1'b0;

  int n5, n10, nrej, tick_no, first_code_tick;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DB),
    .LOCKOUT_CYCLES (LK),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coin5_raw (coin5_raw),
    .coin10_raw(coin10_raw),
    .inhibit   (inhibit),
    .coin_code (coin_code),
    .reject    (reject),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit raw_now [2];
    bit all_diff;
    raw_now[0] = coin5_raw;
    raw_now[1] = coin10_raw;
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_shist[ch] = '0;
        m_rawp[ch]  = 1'b0;
        m_filt[ch]  = 1'b0;
        m_filtd[ch] = 1'b0;
        m_rise[ch]  = 1'b0;
      end
      m_code       = 2'b00;
      m_rej        = 1'b0;
      m_idle       = 1'b0;
      m_lock_start = m_cyc;
    end else begin
      m_code = 2'b00;
      m_rej  = 1'b0;
      if (m_idle) begin
        if (m_rise[0] || m_rise[1]) begin
          m_idle       = 1'b0;
          m_lock_start = m_cyc;
          if ((m_rise[0] && m_rise[1]) || inhibit) m_rej = 1'b1;
          else m_code = m_rise[0] ? 2'b01 : 2'b10;
        end
      end else if ((m_cyc - m_lock_start) > LK && !m_filt[0] && !m_filt[1]) begin
        m_idle = 1'b1;
      end
      for (int ch = 0; ch < 2; ch++) begin
        all_diff = 1'b1;
        for (int i = 0; i < DB; i++) if (m_shist[ch][i] == m_filt[ch]) all_diff = 1'b0;
        m_rise[ch]  = m_filt[ch] & ~m_filtd[ch];
        m_filtd[ch] = m_filt[ch];
        if (all_diff) m_filt[ch] = ~m_filt[ch];
        m_shist[ch] = {m_shist[ch][62:0], m_rawp[ch]};
        m_rawp[ch]  = raw_now[ch];
      end
    end
    m_cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    tick_no++;
    vectors++;
    assert (coin_code === m_code) else begin
      miscompares++;
      $error("FAIL coin_code cyc=%0d got %b want %b", m_cyc, coin_code, m_code);
    end
    assert (reject === m_rej) else begin
      miscompares++;
      $error("FAIL reject cyc=%0d got %b want %b", m_cyc, reject, m_rej);
    end
    assert (busy === !m_idle) else begin
      miscompares++;
      $error("FAIL busy cyc=%0d got %b want %b", m_cyc, busy, !m_idle);
    end
    if (coin_code === 2'b01) begin
      n5++;
      if (first_code_tick < 0) first_code_tick = tick_no;
    end
    if (coin_code === 2'b10) begin
      n10++;
      if (first_code_tick < 0) first_code_tick = tick_no;
    end
    if (reject === 1'b1) nrej++;
    $display("cyc=%0d rst=%b c5=%b c10=%b inh=%b -> code=%b rej=%b busy=%b",
             m_cyc, rst, coin5_raw, coin10_raw, inhibit, coin_code, reject, busy);
  endtask

  task automatic check(input string tag, input int got, input int want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic clear_counts();
    n5 = 0;
    n10 = 0;
    nrej = 0;
    tick_no = 0;
    first_code_tick = -1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      tick();
      k++;
    end
    check(tag, (busy === 1'b0) ? 1 : 0, 1);
  endtask

  task automatic pulse_line(input int which, input int cycles);
    if (which == 5) coin5_raw = 1'b1;
    else coin10_raw = 1'b1;
    repeat (cycles) tick();
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
  endtask

  initial begin
    clear_counts();

    // Reset then idle
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (8) tick();
    check("busy_lockout_held", busy, 1);
    tick();
    check("busy_lockout_done", busy, 0);
    repeat (3) tick();

    // Clean 5 rs coin
    clear_counts();
    pulse_line(5, 20);
    check("latency5", first_code_tick, 8);
    wait_idle("idle_after_5");
    repeat (5) tick();
    check("clean5_n5", n5, 1);
    check("clean5_n10", n10, 0);
    check("clean5_rej", nrej, 0);

    // Bounce and short glitch never qualify
    clear_counts();
    for (int i = 0; i < 6; i++) begin
      coin10_raw = (i % 2 == 0);
      tick();
    end
    pulse_line(10, 3);
    repeat (12) tick();
    check("bounce_n10", n10, 0);
    check("bounce_rej", nrej, 0);
    clear_counts();
    pulse_line(10, 10);
    wait_idle("idle_after_10");
    repeat (3) tick();
    check("stable10_n10", n10, 1);

    // Simultaneous insertion
    clear_counts();
    coin5_raw  = 1'b1;
    coin10_raw = 1'b1;
    repeat (10) tick();
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    check("simul_busy", busy, 1);
    wait_idle("idle_after_simul");
    check("simul_rej", nrej, 1);
    check("simul_codes", n5 + n10, 0);

    // Inhibit
    clear_counts();
    inhibit = 1'b1;
    pulse_line(10, 10);
    wait_idle("idle_after_inh");
    check("inh_rej", nrej, 1);
    check("inh_n10", n10, 0);
    inhibit = 1'b0;
    clear_counts();
    pulse_line(5, 10);
    wait_idle("idle_after_inh5");
    check("inh_then5_n5", n5, 1);

    // 5 rs inserted while locked on a 10 rs coin
    clear_counts();
    coin10_raw = 1'b1;
    repeat (5) tick();
    coin5_raw = 1'b1;
    repeat (5) tick();
    coin10_raw = 1'b0;
    repeat (5) tick();
    coin5_raw = 1'b0;
    wait_idle("idle_after_b2b");
    repeat (3) tick();
    check("b2b_n10", n10, 1);
    check("b2b_n5", n5, 0);
    check("b2b_rej", nrej, 0);

    // Coin held across reset
    clear_counts();
    coin5_raw = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (30) tick();
    check("held_busy", busy, 1);
    check("held_n5", n5, 0);
    coin5_raw = 1'b0;
    wait_idle("idle_after_held");
    check("held_release_n5", n5, 0);
    clear_counts();
    pulse_line(5, 10);
    wait_idle("idle_after_new5");
    check("held_new_n5", n5, 1);

    // Random traffic against the model
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(11) == 0) coin5_raw = ~coin5_raw;
      if ($urandom_range(11) == 0) coin10_raw = ~coin10_raw;
      if ($urandom_range(29) == 0) inhibit = ~inhibit;
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0;
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    inhibit = 1'b0;
    wait_idle("idle_after_random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
